// File: rtl/fsm_sorter.sv
// Multi-cycle bubble sorter: captures N unsigned values on start, performs one
// compare/swap per clock, then presents the ascending result with done.
module fsm_sorter #(
  parameter int unsigned N     = 6,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in     [N],
  output logic             done,
  output logic [WIDTH-1:0] data_sorted [N]
);

  // Counter width covers pass/index values 0..N-1.
  localparam int unsigned CW      = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned LastIdx = (N >= 2) ? N - 2 : 0;
  localparam logic [CW-1:0] Last  = CW'(LastIdx);

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q      [N];
  logic [WIDTH-1:0] a_d      [N];
  logic [WIDTH-1:0] sorted_q [N];
  logic [WIDTH-1:0] sorted_d [N];

  // State, working array, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      done_q   <= 1'b0;
      a_q      <= '{default: '0};
      sorted_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      done_q   <= done_d;
      a_q      <= a_d;
      sorted_q <= sorted_d;
    end
  end

  // Next-state: capture on start, one compare/swap per SORT cycle, publish on exit.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    done_d   = done_q;
    a_d      = a_q;
    sorted_d = sorted_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d    = data_in;
          i_d    = '0;
          j_d    = '0;
          done_d = 1'b0;
          if (N == 1) begin
            // A single element is already sorted.
            state_d  = StDone;
            done_d   = 1'b1;
            sorted_d = data_in;
          end else begin
            state_d = StSort;
          end
        end
      end
      StSort: begin
        // Strict greater-than keeps equal values in place.
        for (int k = 0; k < int'(N) - 1; k++) begin
          if (CW'(k) == j_q && a_q[k] > a_q[k+1]) begin
            a_d[k]   = a_q[k+1];
            a_d[k+1] = a_q[k];
          end
        end
        if (j_q == Last - i_q) begin
          j_d = '0;
          i_d = i_q + 1'b1;
          if (i_q == Last) begin
            state_d  = StDone;
            done_d   = 1'b1;
            sorted_d = a_d;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign done        = done_q;
  assign data_sorted = sorted_q;

endmodule

// File: tb/tb_fsm_sorter.sv
// Self-checking bench for fsm_sorter: table vectors, random vs. a queue-sort
// model, and hand-written multi-cycle sequences; also N=1 and N=2 instances.
module tb_fsm_sorter;

  typedef logic [5:0][7:0] vec6_t;
  typedef struct {
    string name;
    vec6_t din;
    vec6_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start6, start1, start2;
  logic [7:0] din6 [6];
  logic [7:0] out6 [6];
  logic       done6;
  logic [7:0] din1 [1];
  logic [7:0] out1 [1];
  logic       done1;
  logic [3:0] din2 [2];
  logic [3:0] out2 [2];
  logic       done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_sorter #(.N(6), .WIDTH(8)) u6 (
    .clk(clk), .rst(rst), .start(start6), .data_in(din6), .done(done6), .data_sorted(out6)
  );
  fsm_sorter #(.N(1), .WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(din1), .done(done1), .data_sorted(out1)
  );
  fsm_sorter #(.N(2), .WIDTH(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(din2), .done(done2), .data_sorted(out2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec6_t mk(int a0, int a1, int a2, int a3, int a4, int a5);
    vec6_t v;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2);
    v[3] = 8'(a3); v[4] = 8'(a4); v[5] = 8'(a5);
    return v;
  endfunction

  function automatic vec6_t out_packed();
    vec6_t v;
    for (int k = 0; k < 6; k++) v[k] = out6[k];
    return v;
  endfunction

  // Reference: ascending sort of the six values.
  function automatic vec6_t model(vec6_t v);
    int    q[$];
    vec6_t r;
    for (int k = 0; k < 6; k++) q.push_back(int'(v[k]));
    q.sort();
    for (int k = 0; k < 6; k++) r[k] = 8'(q[k]);
    return r;
  endfunction

  task automatic drive6(input vec6_t v);
    for (int k = 0; k < 6; k++) din6[k] = v[k];
  endtask

  // Latency counts the start edge as clock 1.
  task automatic run6(input vec6_t v, output int lat);
    drive6(v);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    lat = 1;
    while (!done6 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  vec_t  tbl[5];
  vec6_t va, vb, vc, rnd;
  int    lat, hi, consec, stable;
  logic  prev_done;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"basic",   mk(34, 7, 200, 7, 0, 255), mk(0, 7, 7, 34, 200, 255)};
    tbl[1] = '{"sorted",  mk(1, 2, 3, 4, 5, 6),      mk(1, 2, 3, 4, 5, 6)};
    tbl[2] = '{"reverse", mk(6, 5, 4, 3, 2, 1),      mk(1, 2, 3, 4, 5, 6)};
    tbl[3] = '{"equal",   mk(9, 9, 9, 9, 9, 9),      mk(9, 9, 9, 9, 9, 9)};
    tbl[4] = '{"extreme", mk(255, 0, 255, 0, 128, 1), mk(0, 0, 1, 128, 255, 255)};

    rst = 1'b1; start6 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    drive6('0); din1[0] = '0; din2[0] = '0; din2[1] = '0;
    #1;
    chk("reset_done6", 64'(done6), 64'd0);
    chk("reset_out6", 64'(out_packed()), 64'd0);
    chk("reset_done1", 64'(done1), 64'd0);
    chk("reset_done2", 64'(done2), 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_done6", 64'(done6), 64'd0);

    // Table vectors.
    for (int t = 0; t < 5; t++) begin
      run6(tbl[t].din, lat);
      chk({tbl[t].name, "_latency"}, 64'(lat), 64'd16);
      chk({tbl[t].name, "_result"}, 64'(out_packed()), 64'(tbl[t].exp));
      step();
      chk({tbl[t].name, "_hold"}, 64'({done6, out_packed()}), 64'({1'b1, tbl[t].exp}));
    end

    // Randomized vectors; odd iterations use a tiny range to force duplicates.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 6; k++)
        rnd[k] = (it % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run6(rnd, lat);
      chk("rand_latency", 64'(lat), 64'd16);
      chk("rand_result", 64'(out_packed()), 64'(model(rnd)));
    end

    // Back-to-back: done drops, old result held until new one lands.
    va = mk(50, 40, 30, 20, 10, 0);
    vb = mk(3, 200, 3, 100, 7, 1);
    run6(va, lat);
    drive6(vb);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    chk("b2b_done_drop", 64'(done6), 64'd0);
    chk("b2b_old_held", 64'(out_packed()), 64'(model(va)));
    lat = 1;
    stable = 1;
    while (!done6 && lat < 100) begin
      if (out_packed() != model(va)) stable = 0;
      step();
      lat++;
    end
    chk("b2b_no_partial", 64'(stable), 64'd1);
    chk("b2b_latency", 64'(lat), 64'd16);
    chk("b2b_result", 64'(out_packed()), 64'(model(vb)));

    // Input isolation: new data and start during SORT are ignored.
    va = mk(90, 80, 70, 60, 50, 40);
    vc = mk(1, 1, 1, 1, 1, 1);
    drive6(va);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    step(); step();
    drive6(vc);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    lat = 4;
    while (!done6 && lat < 100) begin
      step();
      lat++;
    end
    chk("iso_latency", 64'(lat), 64'd16);
    chk("iso_result", 64'(out_packed()), 64'(model(va)));

    // Start held high from DONE: restart every sort, done high one cycle each.
    drive6(vb);
    start6 = 1'b1;
    hi = 0;
    consec = 0;
    prev_done = 1'b0;
    for (int s = 0; s < 33; s++) begin
      step();
      if (done6) hi++;
      if (done6 && prev_done) consec = 1;
      prev_done = done6;
    end
    start6 = 1'b0;
    chk("held_done_count", 64'(hi), 64'd2);
    chk("held_done_single", 64'(consec), 64'd0);
    lat = 0;
    while (!done6 && lat < 100) begin
      step();
      lat++;
    end
    chk("held_final", 64'(out_packed()), 64'(model(vb)));

    // Asynchronous reset mid-sort.
    drive6(va);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    step(); step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_done", 64'(done6), 64'd0);
    chk("rst_async_out", 64'(out_packed()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stable = 1;
    for (int s = 0; s < 20; s++) begin
      step();
      if (done6) stable = 0;
    end
    chk("rst_stays_idle", 64'(stable), 64'd1);
    chk("rst_out_zero", 64'(out_packed()), 64'd0);

    // N = 1: done after the start edge itself.
    din1[0] = 8'd173;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1_done", 64'(done1), 64'd1);
    chk("n1_out", 64'(out1[0]), 64'd173);
    din1[0] = 8'd5;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("n1_out2", 64'({done1, out1[0]}), 64'({1'b1, 8'd5}));

    // N = 2, WIDTH = 4.
    din2[0] = 4'd15; din2[1] = 4'd0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("n2_not_yet", 64'(done2), 64'd0);
    step();
    chk("n2_done", 64'(done2), 64'd1);
    chk("n2_out", 64'({out2[1], out2[0]}), 64'({4'd15, 4'd0}));
    din2[0] = 4'd5; din2[1] = 4'd5;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    chk("n2_equal", 64'({done2, out2[1], out2[0]}), 64'({1'b1, 4'd5, 4'd5}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
